// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the write-back register file and its
// destination mapper: icode values, register index constants, the data
// width and the write-back sequencing states.
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // IDLE accepts commands; WR_M finishes the second write of popq.
    typedef enum logic {
        IDLE = 1'b0,
        WR_M = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational mapping from an instruction's icode/cnd/rA/rB to its
// write-back destinations. dst_e receives valE, dst_m receives valM;
// RNONE means no write. Codes 0xC-0xF are flagged as illegal.
module wb_dst_sel #(
    parameter int RSP_IDX = 4
) (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m,
    output logic       illegal
);
    import y86_pkg::*;

    localparam logic [3:0] RSP = 4'(RSP_IDX);

    // Destination decode per instruction class
    always_comb begin
        dst_e   = RNONE;
        dst_m   = RNONE;
        illegal = 1'b0;
        case (icode)
            IHALT, INOP, IRMMOVQ, IJXX: begin
                dst_e = RNONE;
            end
            ICMOVXX: begin
                if (cnd) dst_e = rB;
            end
            IIRMOVQ, IOPQ: begin
                dst_e = rB;
            end
            IMRMOVQ: begin
                dst_m = rA;
            end
            ICALL, IRET, IPUSHQ: begin
                dst_e = RSP;
            end
            IPOPQ: begin
                dst_e = RSP;
                dst_m = rA;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 write-back register file: 15 architectural registers behind one
// physical write port, two combinational read ports for decode. popq is
// sequenced over two cycles (E-write, then the latched M-write).
// Optional macro WB_BYPASS_EN forwards the value being written at the
// upcoming edge onto a matching read port.
module wb_regfile #(
    parameter int DATA_W  = y86_pkg::DATA_W,
    parameter int NREGS   = 15,
    parameter int RSP_IDX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic              wb_done,
    output logic              err
);
    import y86_pkg::*;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    wb_state_t         state_q, state_d;
    logic [3:0]        m_dst_q, m_dst_d;
    logic [DATA_W-1:0] m_val_q, m_val_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        dst_e, dst_m;
    logic              illegal;
    logic              accept;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    wb_dst_sel #(
        .RSP_IDX (RSP_IDX)
    ) u_dst_sel (
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .dst_e   (dst_e),
        .dst_m   (dst_m),
        .illegal (illegal)
    );

    assign accept = in_valid & in_ready;

    // State register: reset drops any pending popq M-write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, single write-port selection and popq M-write latching
    always_comb begin
        state_d = state_q;
        m_dst_d = m_dst_q;
        m_val_d = m_val_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = RNONE;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    err_d  = illegal;
                    // E has priority; only popq carries both, and its M half is deferred
                    if (dst_e != RNONE) begin
                        wr_en   = 1'b1;
                        wr_idx  = dst_e;
                        wr_data = valE;
                    end else if (dst_m != RNONE) begin
                        wr_en   = 1'b1;
                        wr_idx  = dst_m;
                        wr_data = valM;
                    end
                    if (icode == IPOPQ && dst_m != RNONE) begin
                        state_d = WR_M;
                        m_dst_d = dst_m;
                        m_val_d = valM;
                        done_d  = 1'b0;
                    end
                end
            end
            WR_M: begin
                wr_en   = 1'b1;
                wr_idx  = m_dst_q;
                wr_data = m_val_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Register array next value from the write port
    always_comb begin
        regs_d = regs_q;
        if (wr_en && int'(wr_idx) < NREGS) regs_d[wr_idx] = wr_data;
    end

    // Register array, latched popq M-write and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            m_dst_q <= RNONE;
            m_val_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            m_dst_q <= m_dst_d;
            m_val_q <= m_val_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs: handshake, status pulses and the two read ports
    always_comb begin
        in_ready = (state_q == IDLE);
        wb_done  = done_q;
        err      = err_q;
        rdA      = '0;
        rdB      = '0;
        if (int'(srcA) < NREGS) rdA = regs_q[srcA];
        if (int'(srcB) < NREGS) rdB = regs_q[srcB];
`ifdef WB_BYPASS_EN
        if (wr_en && srcA != RNONE && srcA == wr_idx) rdA = wr_data;
        if (wr_en && srcB != RNONE && srcB == wr_idx) rdB = wr_data;
`else
`endif
    end

endmodule
